// File: rtl/mem_stage_if.sv
// EX->MEM, MEM->WB and decode-bypass signals seen by the memory-access stage.
// master: the stage itself; slave: its neighbours (EX, SRAM, WB, decode).
interface mem_stage_if;
    logic        EX_valid;
    logic [73:0] EX_signal;
    logic [31:0] data_sram_rdata;
    logic        WB_allowin;
    logic        MEM_allowin;
    logic        MEM_readygo;
    logic        MEM_to_WB_valid;
    logic [69:0] MEM_to_WB_signal;
    logic        fwd_we;
    logic [4:0]  fwd_waddr;
    logic [31:0] fwd_wdata;
    logic        fwd_is_load;

    modport master (
        input  EX_valid, EX_signal, data_sram_rdata, WB_allowin,
        output MEM_allowin, MEM_readygo, MEM_to_WB_valid, MEM_to_WB_signal,
               fwd_we, fwd_waddr, fwd_wdata, fwd_is_load
    );

    modport slave (
        output EX_valid, EX_signal, data_sram_rdata, WB_allowin,
        input  MEM_allowin, MEM_readygo, MEM_to_WB_valid, MEM_to_WB_signal,
               fwd_we, fwd_waddr, fwd_wdata, fwd_is_load
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EX bus, holds the SRAM read word
// across WB stalls, extracts load data and presents the result to WB/decode.
module mem_stage (
    input  logic          clk,
    input  logic          reset,
    mem_stage_if.master   bus
);
    logic        valid_r;
    logic [73:0] bus_r;
    logic        first_r;
    logic [31:0] rbuf_r;
    logic        rbuf_v_r;

    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic [2:0]  ld_type;
    logic        mem_allowin;
    logic [31:0] rdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign {pc, rf_we, rf_waddr, alu_result, res_from_mem, ld_type} = bus_r;

    assign mem_allowin = !valid_r || (bus.MEM_readygo && bus.WB_allowin);

    // Once the first cycle has passed the SRAM output is no longer ours,
    // so a stalled load reads from the captured copy instead.
    assign rdata = rbuf_v_r ? rbuf_r : bus.data_sram_rdata;

    // Byte/half lane selection from the low address bits.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        case (alu_result[1:0])
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = alu_result[1] ? rdata[31:16] : rdata[15:0];
    end

    // Sign/zero extension by load type; unused encodings return zero.
    always_comb begin
        load_data = 32'h0;
        case (ld_type)
            3'b000:  load_data = rdata;
            3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b011:  load_data = {24'h0, byte_sel};
            3'b010:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {16'h0, half_sel};
            default: load_data = 32'h0;
        endcase
    end

    assign final_result = res_from_mem ? load_data : alu_result;

    assign bus.MEM_readygo      = 1'b1;
    assign bus.MEM_allowin      = mem_allowin;
    assign bus.MEM_to_WB_valid  = valid_r && bus.MEM_readygo;
    assign bus.MEM_to_WB_signal = {pc, rf_we, rf_waddr, final_result};
    assign bus.fwd_we           = valid_r && rf_we;
    assign bus.fwd_waddr        = rf_waddr;
    assign bus.fwd_wdata        = final_result;
    assign bus.fwd_is_load      = valid_r && res_from_mem;

    // Stage register, first-cycle flag and read-data hold buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r  <= 1'b0;
            bus_r    <= 74'h0;
            first_r  <= 1'b0;
            rbuf_r   <= 32'h0;
            rbuf_v_r <= 1'b0;
        end else begin
            if (mem_allowin) begin
                valid_r <= bus.EX_valid;
            end
            if (bus.EX_valid && mem_allowin) begin
                bus_r    <= bus.EX_signal;
                first_r  <= 1'b1;
                rbuf_v_r <= 1'b0;
            end else begin
                first_r <= 1'b0;
                if (valid_r && first_r && !bus.WB_allowin) begin
                    rbuf_r   <= bus.data_sram_rdata;
                    rbuf_v_r <= 1'b1;
                end
            end
        end
    end
endmodule
